// File: rtl/ml_peak_ctrl.sv
// Windowed peak search over a stream of signed lambda metrics, reporting per-window peak index, angle and value.
// Optional ML_LOCK_EN macro adds a lock indicator tracking peak-index stability between consecutive windows.
module ml_peak_ctrl #(
    parameter int WIN_LEN = 256,
    parameter int NUM_WIN = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        lam_valid,
    output logic        lam_ready,
    input  logic [13:0] lambda_in,
    input  logic [10:0] ang_in,
    output logic        res_valid,
    output logic [7:0]  theta_o,
    output logic [10:0] ang_o,
    output logic [13:0] lmax_o,
    output logic        busy,
    output logic        done,
    output logic        lock_o
);

    localparam logic [7:0] LAST_IDX = 8'(WIN_LEN - 1);
    localparam logic [3:0] LAST_WIN = 4'(NUM_WIN - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        UPDATE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state;
    logic [7:0]         cnt;
    logic [3:0]         win_cnt;
    logic [7:0]         cand_theta;
    logic [10:0]        cand_ang;
    logic signed [13:0] cand_lmax;

    logic               accept;
    logic               take;
    logic [7:0]         nxt_theta;
    logic [10:0]        nxt_ang;
    logic signed [13:0] nxt_lmax;

    assign accept = lam_valid && lam_ready;

    // First sample of a window always loads; later ones must beat the max strictly so ties keep the earliest index.
    always_comb begin
        take      = (cnt == 8'd0) || ($signed(lambda_in) > cand_lmax);
        nxt_theta = cand_theta;
        nxt_ang   = cand_ang;
        nxt_lmax  = cand_lmax;
        if (take) begin
            nxt_theta = cnt;
            nxt_ang   = ang_in;
            nxt_lmax  = $signed(lambda_in);
        end
    end

    // Results are registered on the edge that accepts the last sample, so they are presented during UPDATE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lam_ready  <= 1'b0;
            busy       <= 1'b0;
            res_valid  <= 1'b0;
            done       <= 1'b0;
            cnt        <= 8'd0;
            win_cnt    <= 4'd0;
            cand_theta <= 8'd0;
            cand_ang   <= 11'd0;
            cand_lmax  <= 14'sd0;
            theta_o    <= 8'd0;
            ang_o      <= 11'd0;
            lmax_o     <= 14'd0;
        end else begin
            res_valid <= 1'b0;
            done      <= 1'b0;
            if (abort) begin
                state      <= IDLE;
                lam_ready  <= 1'b0;
                busy       <= 1'b0;
                cnt        <= 8'd0;
                win_cnt    <= 4'd0;
                cand_theta <= 8'd0;
                cand_ang   <= 11'd0;
                cand_lmax  <= 14'sd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state     <= ACQ;
                            lam_ready <= 1'b1;
                            busy      <= 1'b1;
                            cnt       <= 8'd0;
                            win_cnt   <= 4'd0;
                        end
                    end
                    ACQ: begin
                        if (accept) begin
                            cand_theta <= nxt_theta;
                            cand_ang   <= nxt_ang;
                            cand_lmax  <= nxt_lmax;
                            if (cnt == LAST_IDX) begin
                                state     <= UPDATE;
                                lam_ready <= 1'b0;
                                cnt       <= 8'd0;
                                theta_o   <= nxt_theta;
                                ang_o     <= nxt_ang;
                                lmax_o    <= nxt_lmax;
                                res_valid <= 1'b1;
                            end else begin
                                cnt <= cnt + 8'd1;
                            end
                        end
                    end
                    UPDATE: begin
                        cnt     <= 8'd0;
                        win_cnt <= win_cnt + 4'd1;
                        if (win_cnt != LAST_WIN) begin
                            state     <= ACQ;
                            lam_ready <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                    DONE: begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        win_cnt <= 4'd0;
                    end
                    default: begin
                        state     <= IDLE;
                        lam_ready <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef ML_LOCK_EN
    logic [7:0] prev_theta;
    logic       prev_valid;
    logic       lock_reg;
    logic [8:0] dist;
    logic       near;

    // Circular distance modulo WIN_LEN, so the last and first indices count as neighbours.
    always_comb begin
        if (theta_o >= prev_theta)
            dist = {1'b0, theta_o} - {1'b0, prev_theta};
        else
            dist = {1'b0, theta_o} + 9'(WIN_LEN) - {1'b0, prev_theta};
        near = (dist <= 9'd1) || (dist == 9'(WIN_LEN - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_theta <= 8'd0;
            prev_valid <= 1'b0;
            lock_reg   <= 1'b0;
        end else if (abort || (state == IDLE && start)) begin
            prev_theta <= 8'd0;
            prev_valid <= 1'b0;
            lock_reg   <= 1'b0;
        end else if (state == UPDATE) begin
            if (prev_valid)
                lock_reg <= near;
            prev_theta <= theta_o;
            prev_valid <= 1'b1;
        end
    end

    assign lock_o = lock_reg;
`else
    assign lock_o = 1'b0;
`endif

endmodule

// File: tb/tb_ml_peak_ctrl.sv
// Directed bench: table of single-window vectors plus hand sequences for abort, async reset and lock tracking.
module tb_ml_peak_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lam_valid;
    logic [13:0] lambda_in;
    logic [10:0] ang_in;
    logic        start_a, abort_a, start_b, abort_b, start_c, abort_c;

    logic        lam_ready_a, res_valid_a, busy_a, done_a, lock_a;
    logic [7:0]  theta_a;
    logic [10:0] ang_a;
    logic [13:0] lmax_a;
    logic        lam_ready_b, res_valid_b, busy_b, done_b, lock_b;
    logic [7:0]  theta_b;
    logic [10:0] ang_b;
    logic [13:0] lmax_b;
    logic        lam_ready_c, res_valid_c, busy_c, done_c, lock_c;
    logic [7:0]  theta_c;
    logic [10:0] ang_c;
    logic [13:0] lmax_c;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ml_peak_ctrl #(.WIN_LEN(8), .NUM_WIN(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .lam_valid(lam_valid), .lam_ready(lam_ready_a), .lambda_in(lambda_in), .ang_in(ang_in),
        .res_valid(res_valid_a), .theta_o(theta_a), .ang_o(ang_a), .lmax_o(lmax_a),
        .busy(busy_a), .done(done_a), .lock_o(lock_a));

    ml_peak_ctrl #(.WIN_LEN(8), .NUM_WIN(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .lam_valid(lam_valid), .lam_ready(lam_ready_b), .lambda_in(lambda_in), .ang_in(ang_in),
        .res_valid(res_valid_b), .theta_o(theta_b), .ang_o(ang_b), .lmax_o(lmax_b),
        .busy(busy_b), .done(done_b), .lock_o(lock_b));

    ml_peak_ctrl #(.WIN_LEN(256), .NUM_WIN(3)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .abort(abort_c),
        .lam_valid(lam_valid), .lam_ready(lam_ready_c), .lambda_in(lambda_in), .ang_in(ang_in),
        .res_valid(res_valid_c), .theta_o(theta_c), .ang_o(ang_c), .lmax_o(lmax_c),
        .busy(busy_c), .done(done_c), .lock_o(lock_c));

`ifdef ML_LOCK_EN
    localparam logic [2:0] LOCK_EXP = 3'b010;
`else
    localparam logic [2:0] LOCK_EXP = 3'b000;
`endif

    typedef struct {
        logic [7:0][13:0] lam;     // lam[j] is sample j
        bit               gap;
        logic [7:0]       e_theta;
        logic [13:0]      e_lmax;
        logic [10:0]      e_ang;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Peak value/angle at index pk, filler 0x0010 everywhere else.
    task automatic feed_peak(input int n, input int pk, input logic [13:0] pv, input logic [10:0] pa);
        for (int i = 0; i < n; i++) begin
            lam_valid = 1'b1;
            lambda_in = (i == pk) ? pv : 14'h0010;
            ang_in    = (i == pk) ? pa : 11'(i);
            tick();
        end
        lam_valid = 1'b0;
    endtask

    task automatic run_vec(input int v);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("acq_ready", 32'(lam_ready_a), 1);
        check("acq_busy", 32'(busy_a), 1);
        for (int j = 0; j < 8; j++) begin
            lam_valid = 1'b1;
            start_a   = (j == 3);
            lambda_in = tbl[v].lam[j];
            ang_in    = 11'h050 + 11'(v * 16 + j);
            tick();
            start_a = 1'b0;
            if (tbl[v].gap && j < 7) begin
                lam_valid = 1'b0;
                lambda_in = 14'h1FFF;
                ang_in    = 11'h7FF;
                tick();
            end
        end
        lam_valid = 1'b0;
        check("upd_res_valid", 32'(res_valid_a), 1);
        check("upd_theta", 32'(theta_a), 32'(tbl[v].e_theta));
        check("upd_lmax", 32'(lmax_a), 32'(tbl[v].e_lmax));
        check("upd_ang", 32'(ang_a), 32'(tbl[v].e_ang));
        check("upd_ready", 32'(lam_ready_a), 0);
        $display("vec %0d: theta=%0d lmax=%h ang=%h", v, theta_a, lmax_a, ang_a);
        tick();
        check("done_pulse", 32'(done_a), 1);
        check("done_res_valid", 32'(res_valid_a), 0);
        check("done_ready", 32'(lam_ready_a), 0);
        tick();
        check("idle_done", 32'(done_a), 0);
        check("idle_busy", 32'(busy_a), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        int pk[3];

        tbl[0] = '{lam: {14'h180, 14'h140, 14'h300, 14'h100, 14'h0C0, 14'h080, 14'h040, 14'h000},
                   gap: 1'b0, e_theta: 8'd5, e_lmax: 14'h0300, e_ang: 11'h055};
        tbl[1] = '{lam: {14'h010, 14'h100, 14'h010, 14'h010, 14'h010, 14'h100, 14'h010, 14'h010},
                   gap: 1'b0, e_theta: 8'd2, e_lmax: 14'h0100, e_ang: 11'h062};
        tbl[2] = '{lam: {14'h3800, 14'h3FF0, 14'h3D00, 14'h3FF0, 14'h3F80, 14'h3C00, 14'h3E00, 14'h3F00},
                   gap: 1'b0, e_theta: 8'd4, e_lmax: 14'h3FF0, e_ang: 11'h074};
        tbl[3] = '{lam: {14'h3FFF, 14'h0005, 14'h3FFF, 14'h0000, 14'h3FFF, 14'h2000, 14'h3FFF, 14'h3FFF},
                   gap: 1'b0, e_theta: 8'd6, e_lmax: 14'h0005, e_ang: 11'h086};
        tbl[4] = '{lam: {14'h180, 14'h140, 14'h300, 14'h100, 14'h0C0, 14'h080, 14'h040, 14'h000},
                   gap: 1'b1, e_theta: 8'd5, e_lmax: 14'h0300, e_ang: 11'h095};
        tbl[5] = '{lam: {14'h0000, 14'h0080, 14'h0100, 14'h0200, 14'h0400, 14'h0800, 14'h1000, 14'h1FFF},
                   gap: 1'b0, e_theta: 8'd0, e_lmax: 14'h1FFF, e_ang: 11'h0A0};
        tbl[6] = '{lam: {14'h0001, 14'h3600, 14'h3500, 14'h3400, 14'h3300, 14'h3200, 14'h3100, 14'h3000},
                   gap: 1'b0, e_theta: 8'd7, e_lmax: 14'h0001, e_ang: 11'h0B7};
        tbl[7] = '{lam: {8{14'h2000}},
                   gap: 1'b0, e_theta: 8'd0, e_lmax: 14'h2000, e_ang: 11'h0C0};

        rst_n = 1'b0;
        lam_valid = 1'b0; lambda_in = '0; ang_in = '0;
        start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0; start_c = 1'b0; abort_c = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(lam_ready_a), 0);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_res_valid", 32'(res_valid_a), 0);
        check("rst_done", 32'(done_a), 0);
        check("rst_theta", 32'(theta_a), 0);
        check("rst_lmax", 32'(lmax_a), 0);
        check("rst_lock", 32'(lock_c), 0);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 8; v++) run_vec(v);

        // abort and start together: abort wins
        start_a = 1'b1; abort_a = 1'b1;
        tick();
        start_a = 1'b0; abort_a = 1'b0;
        check("abort_start_busy", 32'(busy_a), 0);
        check("abort_start_ready", 32'(lam_ready_a), 0);

        // abort at sample 3 of the second window
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        feed_peak(8, 3, 14'h0200, 11'h033);
        check("b_w0_valid", 32'(res_valid_b), 1);
        check("b_w0_theta", 32'(theta_b), 3);
        tick();
        check("b_w1_ready", 32'(lam_ready_b), 1);
        for (int j = 0; j < 3; j++) begin
            lam_valid = 1'b1; lambda_in = 14'h0010; ang_in = 11'(j);
            tick();
        end
        lam_valid = 1'b1; abort_b = 1'b1;
        tick();
        abort_b = 1'b0;
        check("abort_busy", 32'(busy_b), 0);
        check("abort_ready", 32'(lam_ready_b), 0);
        check("abort_theta_held", 32'(theta_b), 3);
        check("abort_lmax_held", 32'(lmax_b), 'h0200);
        check("abort_ang_held", 32'(ang_b), 'h033);
        pulses = 0;
        repeat (12) begin
            tick();
            if (res_valid_b || done_b || busy_b) pulses++;
        end
        lam_valid = 1'b0;
        check("abort_no_pulse", 32'(pulses), 0);

        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        check("restart_theta_held", 32'(theta_b), 3);
        check("restart_busy", 32'(busy_b), 1);
        for (int w = 0; w < 4; w++) begin
            feed_peak(8, w + 1, 14'h0100 + 14'(w), 11'h100 + 11'(w));
            check("run_valid", 32'(res_valid_b), 1);
            check("run_theta", 32'(theta_b), 32'(w + 1));
            check("run_lmax", 32'(lmax_b), 32'('h0100 + w));
            $display("run window %0d: theta=%0d lmax=%h", w, theta_b, lmax_b);
            tick();
            check("run_done", 32'(done_b), (w == 3) ? 1 : 0);
        end
        tick();
        check("run_idle_busy", 32'(busy_b), 0);

        // asynchronous reset mid-window
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int j = 0; j < 4; j++) begin
            lam_valid = 1'b1; lambda_in = 14'h0300; ang_in = 11'h011;
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        check("arst_theta", 32'(theta_b), 0);
        check("arst_lmax", 32'(lmax_b), 0);
        check("arst_ang", 32'(ang_b), 0);
        check("arst_busy", 32'(busy_b), 0);
        check("arst_ready", 32'(lam_ready_b), 0);
        check("arst_res_valid", 32'(res_valid_b), 0);
        check("arst_done", 32'(done_b), 0);
        tick();
        rst_n = 1'b1;
        pulses = 0;
        repeat (12) begin
            tick();
            if (res_valid_b || done_b || busy_b || lam_ready_b) pulses++;
        end
        lam_valid = 1'b0;
        check("arst_quiet", 32'(pulses), 0);

        // lock tracking on 256-sample windows
        pk = '{255, 0, 10};
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        check("lock_start", 32'(lock_c), 0);
        for (int w = 0; w < 3; w++) begin
            feed_peak(256, pk[w], 14'h0400, 11'(pk[w]));
            check("lock_res_valid", 32'(res_valid_c), 1);
            check("lock_theta", 32'(theta_c), 32'(pk[w]));
            tick();
            check("lock_state", 32'(lock_c), 32'(LOCK_EXP[w]));
            $display("lock window %0d: theta=%0d lock=%0d", w, theta_c, lock_c);
        end
        check("lock_done", 32'(done_c), 1);
        tick();
        check("lock_idle", 32'(busy_c), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
